// File: rtl/multicycle_core.sv
// Multi-cycle RV32I/RV32E core. A single request/ready bus carries both the
// instruction fetches and the data accesses, so memories may insert wait states.
module multicycle_core #(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter int unsigned REGISTER_COUNT = 32,
  parameter int unsigned COUNTER_WIDTH  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     bus_request,
  output logic                     bus_write,
  output logic [31:0]              bus_address,
  output logic [3:0]               bus_byte_enable,
  output logic [31:0]              bus_write_data,
  input  logic                     bus_ready,
  input  logic [31:0]              bus_read_data,
  output logic [31:0]              program_counter,
  output logic                     halted,
  output logic [1:0]               halt_cause,
  output logic [COUNTER_WIDTH-1:0] retired_count
);

  localparam int unsigned RegIdxWidth = $clog2(REGISTER_COUNT);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [1:0] CauseSystem     = 2'd0;
  localparam logic [1:0] CauseIllegal    = 2'd1;
  localparam logic [1:0] CauseMemAlign   = 2'd2;
  localparam logic [1:0] CauseTargetAlign = 2'd3;

  typedef enum logic [1:0] {StFetch, StExecute, StMemory, StHalt} state_e;

  state_e                   state_q;
  logic [31:0]              pc_q;
  logic [31:0]              instr_q;
  logic [31:0]              mem_addr_q;
  logic [31:0]              store_data_q;
  logic [3:0]               byte_en_q;
  logic                     halted_q;
  logic [1:0]               cause_q;
  logic [COUNTER_WIDTH-1:0] retired_q;

  // Register file; deliberately not reset, x0 is forced to zero on read.
  logic [31:0] regs [REGISTER_COUNT];

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [4:0]  rd_idx;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  assign opcode  = instr_q[6:0];
  assign rd_idx  = instr_q[11:7];
  assign funct3  = instr_q[14:12];
  assign rs1_idx = instr_q[19:15];
  assign rs2_idx = instr_q[24:20];
  assign funct7  = instr_q[31:25];

  assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                  instr_q[11:8], 1'b0};
  assign imm_u = {instr_q[31:12], 12'h000};
  assign imm_j = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                  instr_q[30:21], 1'b0};

  assign rs1_val = (rs1_idx == 5'd0) ? 32'd0 : regs[rs1_idx[RegIdxWidth-1:0]];
  assign rs2_val = (rs2_idx == 5'd0) ? 32'd0 : regs[rs2_idx[RegIdxWidth-1:0]];

  logic legal;
  logic is_system;
  logic uses_rs1;
  logic uses_rs2;
  logic uses_rd;

  // Instruction legality, including the reduced register range of RV32E.
  always_comb begin
    legal    = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    uses_rd  = 1'b0;
    case (opcode)
      OpLui, OpAuipc, OpJal: begin
        legal   = 1'b1;
        uses_rd = 1'b1;
      end
      OpJalr: begin
        legal    = (funct3 == 3'd0);
        uses_rs1 = 1'b1;
        uses_rd  = 1'b1;
      end
      OpBranch: begin
        legal    = (funct3 != 3'd2) && (funct3 != 3'd3);
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OpLoad: begin
        legal    = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
        uses_rs1 = 1'b1;
        uses_rd  = 1'b1;
      end
      OpStore: begin
        legal    = (funct3 < 3'd3);
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OpImm: begin
        if (funct3 == 3'd1)      legal = (funct7 == 7'd0);
        else if (funct3 == 3'd5) legal = (funct7 == 7'd0) || (funct7 == 7'b0100000);
        else                     legal = 1'b1;
        uses_rs1 = 1'b1;
        uses_rd  = 1'b1;
      end
      OpReg: begin
        legal    = (funct7 == 7'd0) ||
                   ((funct7 == 7'b0100000) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        uses_rd  = 1'b1;
      end
      OpFence:  legal = (funct3 == 3'd0);
      OpSystem: legal = (instr_q == 32'h0000_0073) || (instr_q == 32'h0010_0073);
      default:  legal = 1'b0;
    endcase
    if ((REGISTER_COUNT < 32) &&
        ((uses_rs1 && rs1_idx[4]) || (uses_rs2 && rs2_idx[4]) || (uses_rd && rd_idx[4]))) begin
      legal = 1'b0;
    end
  end

  assign is_system = (opcode == OpSystem);

  logic [31:0] alu_b;
  logic [4:0]  shamt;
  logic [31:0] alu_result;

  // ALU shared by OP and OP-IMM; only OP uses funct7[5] to select subtract.
  always_comb begin
    alu_b      = (opcode == OpReg) ? rs2_val : imm_i;
    shamt      = alu_b[4:0];
    alu_result = 32'd0;
    case (funct3)
      3'd0: alu_result = ((opcode == OpReg) && funct7[5]) ? rs1_val - alu_b : rs1_val + alu_b;
      3'd1: alu_result = rs1_val << shamt;
      3'd2: alu_result = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      3'd3: alu_result = {31'd0, rs1_val < alu_b};
      3'd4: alu_result = rs1_val ^ alu_b;
      3'd5: alu_result = funct7[5] ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
      3'd6: alu_result = rs1_val | alu_b;
      default: alu_result = rs1_val & alu_b;
    endcase
  end

  logic branch_taken;

  // Branch comparator.
  always_comb begin
    case (funct3)
      3'd0:    branch_taken = (rs1_val == rs2_val);
      3'd1:    branch_taken = (rs1_val != rs2_val);
      3'd4:    branch_taken = ($signed(rs1_val) < $signed(rs2_val));
      3'd5:    branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'd6:    branch_taken = (rs1_val < rs2_val);
      3'd7:    branch_taken = (rs1_val >= rs2_val);
      default: branch_taken = 1'b0;
    endcase
  end

  logic [31:0] next_pc;
  logic [31:0] wb_data;
  logic        wb_en;
  logic        transfer;
  logic        target_misaligned;

  // Next PC and write-back value for single-cycle instructions.
  always_comb begin
    next_pc  = pc_q + 32'd4;
    wb_data  = alu_result;
    wb_en    = 1'b0;
    transfer = 1'b0;
    case (opcode)
      OpLui: begin
        wb_data = imm_u;
        wb_en   = 1'b1;
      end
      OpAuipc: begin
        wb_data = pc_q + imm_u;
        wb_en   = 1'b1;
      end
      OpJal: begin
        wb_data  = pc_q + 32'd4;
        wb_en    = 1'b1;
        next_pc  = pc_q + imm_j;
        transfer = 1'b1;
      end
      OpJalr: begin
        wb_data  = pc_q + 32'd4;
        wb_en    = 1'b1;
        next_pc  = (rs1_val + imm_i) & ~32'd1;
        transfer = 1'b1;
      end
      OpBranch: begin
        if (branch_taken) begin
          next_pc  = pc_q + imm_b;
          transfer = 1'b1;
        end
      end
      OpImm, OpReg: wb_en = 1'b1;
      default: wb_en = 1'b0;
    endcase
  end

  assign target_misaligned = transfer && next_pc[1];

  logic        is_load;
  logic        is_store;
  logic [31:0] mem_addr;
  logic        mem_misaligned;
  logic [3:0]  byte_en;
  logic [31:0] store_data;

  assign is_load  = (opcode == OpLoad);
  assign is_store = (opcode == OpStore);
  assign mem_addr = rs1_val + (is_store ? imm_s : imm_i);

  // Address check, lane strobes and lane-replicated store data.
  always_comb begin
    mem_misaligned = ((funct3[1:0] == 2'b10) && (mem_addr[1:0] != 2'b00)) ||
                     ((funct3[1:0] == 2'b01) && mem_addr[0]);
    case (funct3[1:0])
      2'b00: begin
        byte_en    = 4'b0001 << mem_addr[1:0];
        store_data = {4{rs2_val[7:0]}};
      end
      2'b01: begin
        byte_en    = mem_addr[1] ? 4'b1100 : 4'b0011;
        store_data = {2{rs2_val[15:0]}};
      end
      default: begin
        byte_en    = 4'b1111;
        store_data = rs2_val;
      end
    endcase
    if (is_load) byte_en = 4'b1111;
  end

  logic [31:0] load_shifted;
  logic [31:0] load_data;

  // Lane select and extension of returned load data.
  always_comb begin
    load_shifted = bus_read_data >> {mem_addr_q[1:0], 3'b000};
    case (funct3)
      3'd0:    load_data = {{24{load_shifted[7]}}, load_shifted[7:0]};
      3'd1:    load_data = {{16{load_shifted[15]}}, load_shifted[15:0]};
      3'd4:    load_data = {24'd0, load_shifted[7:0]};
      3'd5:    load_data = {16'd0, load_shifted[15:0]};
      default: load_data = load_shifted;
    endcase
  end

  logic        exec_retire;
  logic        rf_we;
  logic [31:0] rf_wdata;

  assign exec_retire = legal && !is_system && !target_misaligned && !is_load && !is_store;

  // Register write port; a bus_ready coinciding with reset must not write.
  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = wb_data;
    if (!reset && (rd_idx != 5'd0)) begin
      if ((state_q == StExecute) && exec_retire && wb_en) begin
        rf_we = 1'b1;
      end else if ((state_q == StMemory) && bus_ready && is_load) begin
        rf_we    = 1'b1;
        rf_wdata = load_data;
      end
    end
  end

  // Register file write.
  always_ff @(posedge clk) begin
    if (rf_we) regs[rd_idx[RegIdxWidth-1:0]] <= rf_wdata;
  end

  // Main sequencer: fetch, execute, optional memory phase, halt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StFetch;
      pc_q         <= RESET_VECTOR;
      instr_q      <= 32'd0;
      mem_addr_q   <= 32'd0;
      store_data_q <= 32'd0;
      byte_en_q    <= 4'd0;
      halted_q     <= 1'b0;
      cause_q      <= CauseSystem;
      retired_q    <= '0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (bus_ready) begin
            instr_q <= bus_read_data;
            state_q <= StExecute;
          end
        end
        StExecute: begin
          if (!legal) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
            cause_q  <= CauseIllegal;
          end else if (is_system) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
            cause_q  <= CauseSystem;
          end else if (is_load || is_store) begin
            if (mem_misaligned) begin
              state_q  <= StHalt;
              halted_q <= 1'b1;
              cause_q  <= CauseMemAlign;
            end else begin
              mem_addr_q   <= mem_addr;
              byte_en_q    <= byte_en;
              store_data_q <= store_data;
              state_q      <= StMemory;
            end
          end else if (target_misaligned) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
            cause_q  <= CauseTargetAlign;
          end else begin
            pc_q      <= next_pc;
            retired_q <= retired_q + COUNTER_WIDTH'(1);
            state_q   <= StFetch;
          end
        end
        StMemory: begin
          if (bus_ready) begin
            pc_q      <= pc_q + 32'd4;
            retired_q <= retired_q + COUNTER_WIDTH'(1);
            state_q   <= StFetch;
          end
        end
        StHalt: state_q <= StHalt;
      endcase
    end
  end

  // Bus drive; request is gated by reset so it drops the instant reset rises.
  assign bus_request     = !reset && ((state_q == StFetch) || (state_q == StMemory));
  assign bus_write       = (state_q == StMemory) && is_store;
  assign bus_address     = (state_q == StMemory) ? {mem_addr_q[31:2], 2'b00} : pc_q;
  assign bus_byte_enable = (state_q == StMemory) ? byte_en_q : 4'b1111;
  assign bus_write_data  = store_data_q;

  assign program_counter = pc_q;
  assign halted          = halted_q;
  assign halt_cause      = cause_q;
  assign retired_count   = retired_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: an RV32I instance at 0x100 and an RV32E instance at 0.
module tb_multicycle_core;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpImm   = 7'b0010011;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [31:0] Ecall  = 32'h0000_0073;

  logic        clk;
  logic        reset;
  logic        reset_e;

  logic        bus_request, bus_write, bus_ready, halted;
  logic [31:0] bus_address, bus_write_data, bus_read_data, program_counter, retired_count;
  logic [3:0]  bus_byte_enable;
  logic [1:0]  halt_cause;

  logic        bus_request_e, bus_write_e, bus_ready_e, halted_e;
  logic [31:0] bus_address_e, bus_write_data_e, bus_read_data_e, program_counter_e;
  logic [31:0] retired_count_e;
  logic [3:0]  bus_byte_enable_e;
  logic [1:0]  halt_cause_e;

  multicycle_core #(
    .RESET_VECTOR  (32'h0000_0100),
    .REGISTER_COUNT(32),
    .COUNTER_WIDTH (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus_request    (bus_request),
    .bus_write      (bus_write),
    .bus_address    (bus_address),
    .bus_byte_enable(bus_byte_enable),
    .bus_write_data (bus_write_data),
    .bus_ready      (bus_ready),
    .bus_read_data  (bus_read_data),
    .program_counter(program_counter),
    .halted         (halted),
    .halt_cause     (halt_cause),
    .retired_count  (retired_count)
  );

  multicycle_core #(
    .RESET_VECTOR  (32'h0000_0000),
    .REGISTER_COUNT(16),
    .COUNTER_WIDTH (32)
  ) dut_e (
    .clk            (clk),
    .reset          (reset_e),
    .bus_request    (bus_request_e),
    .bus_write      (bus_write_e),
    .bus_address    (bus_address_e),
    .bus_byte_enable(bus_byte_enable_e),
    .bus_write_data (bus_write_data_e),
    .bus_ready      (bus_ready_e),
    .bus_read_data  (bus_read_data_e),
    .program_counter(program_counter_e),
    .halted         (halted_e),
    .halt_cause     (halt_cause_e),
    .retired_count  (retired_count_e)
  );

  always #5 clk = ~clk;

  // Read-only program/data memories; stores are only logged.
  logic [31:0] mem   [256];
  logic [31:0] mem_e [64];
  assign bus_read_data   = mem[bus_address[9:2]];
  assign bus_read_data_e = mem_e[bus_address_e[7:2]];

  // Wait-state generator for the main instance.
  int         wait_states;
  logic       hold;
  logic [3:0] wait_cnt;
  assign bus_ready   = !hold && (int'(wait_cnt) >= wait_states);
  assign bus_ready_e = 1'b1;

  always @(posedge clk or posedge reset) begin
    if (reset) wait_cnt <= 4'd0;
    else if (bus_request) wait_cnt <= bus_ready ? 4'd0 : wait_cnt + 4'd1;
  end

  // Completed-transaction log.
  logic [31:0] st_addr [16];
  logic [31:0] st_data [16];
  logic [3:0]  st_be   [16];
  int          st_n, rd_n;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      st_n <= 0;
      rd_n <= 0;
    end else if (bus_request && bus_ready) begin
      if (bus_write) begin
        if (st_n < 16) begin
          st_addr[st_n] <= bus_address;
          st_data[st_n] <= bus_write_data;
          st_be[st_n]   <= bus_byte_enable;
        end
        st_n <= st_n + 1;
      end else begin
        rd_n <= rd_n + 1;
      end
    end
  end

  int          st_e_n;
  logic [31:0] st_e_data;

  always @(posedge clk or posedge reset_e) begin
    if (reset_e) begin
      st_e_n    <= 0;
      st_e_data <= 32'd0;
    end else if (bus_request_e && bus_ready_e && bus_write_e) begin
      if (st_e_n == 0) st_e_data <= bus_write_data_e;
      st_e_n <= st_e_n + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic wait_halt(input bit use_e, input int limit, input string tag);
    int n = 0;
    while (!(use_e ? halted_e : halted) && (n < limit)) begin
      tick(1);
      n++;
    end
    checks++;
    assert ((use_e ? halted_e : halted) === 1'b1) else begin
      errors++;
      $error("FAIL %s: halted observed 0 expected 1 within %0d cycles", tag, limit);
    end
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                        input int rd, input logic [6:0] op);
    logic [31:0] im, a, f, d;
    im = imm; a = rs1; f = f3; d = rd;
    return {im[11:0], a[4:0], f[2:0], d[4:0], op};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1,
                                        input int f3);
    logic [31:0] im, a, b, f;
    im = imm; a = rs1; b = rs2; f = f3;
    return {im[11:5], b[4:0], a[4:0], f[2:0], im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
    logic [31:0] im, d;
    im = imm20; d = rd;
    return {im[19:0], d[4:0], op};
  endfunction

  function automatic logic [31:0] enc_j(input int off, input int rd);
    logic [31:0] o, d;
    o = off; d = rd;
    return {o[20], o[10:1], o[11], o[19:12], d[4:0], 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
    logic [31:0] s, a, b, f, d;
    s = f7; a = rs1; b = rs2; f = f3; d = rd;
    return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'b0110011};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] data);
    mem[addr[9:2]] = data;
  endtask

  task automatic load_prog_a();
    put(32'h100, enc_i(5, 0, 0, 1, OpImm));       // addi x1,x0,5
    put(32'h104, enc_i(-7, 1, 0, 2, OpImm));      // addi x2,x1,-7
    put(32'h108, enc_s(32'h300, 2, 0, 2));        // sw x2,0x300(x0)
    put(32'h10C, Ecall);
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b0;
    reset_e = 1'b0;
    hold = 1'b0;
    wait_states = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    for (int i = 0; i < 64; i++) mem_e[i] = 32'd0;
    load_prog_a();
    mem_e[0] = enc_i(7, 0, 0, 3, OpImm);          // addi x3,x0,7
    mem_e[1] = enc_s(32'h40, 3, 0, 2);            // sw x3,0x40(x0)
    mem_e[2] = enc_r(0, 2, 1, 0, 17);             // add x17,x1,x2

    // Reset state
    #2;
    reset = 1'b1;
    reset_e = 1'b1;
    tick(2);
    check("rst_request", {31'd0, bus_request}, 32'd0);
    check("rst_pc", program_counter, 32'h100);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_retired", retired_count, 32'd0);
    reset = 1'b0;
    #1;
    check("first_req", {31'd0, bus_request}, 32'd1);
    check("first_addr", bus_address, 32'h100);
    check("first_write", {31'd0, bus_write}, 32'd0);
    check("first_be", {28'd0, bus_byte_enable}, 32'hF);

    // Two addi's, zero-wait bus
    tick(4);
    check("addi_retired4", retired_count, 32'd2);
    check("addi_pc4", program_counter, 32'h108);
    wait_halt(1'b0, 20, "prog_a_halt");
    check("x2_store_data", st_data[0], 32'hFFFF_FFFE);
    check("x2_store_addr", st_addr[0], 32'h300);
    check("x2_store_be", {28'd0, st_be[0]}, 32'hF);
    check("ecall_cause", {30'd0, halt_cause}, 32'd0);
    check("ecall_pc", program_counter, 32'h10C);
    check("ecall_retired", retired_count, 32'd3);
    check("halt_no_request", {31'd0, bus_request}, 32'd0);

    // Same program, 3 wait cycles per transaction
    wait_states = 3;
    do_reset();
    tick(9);
    check("wait_retired9", retired_count, 32'd1);
    tick(1);
    check("wait_retired10", retired_count, 32'd2);
    wait_states = 0;
    wait_halt(1'b0, 40, "wait_halt");
    check("wait_x2", st_data[0], 32'hFFFF_FFFE);

    // Byte store, signed byte load, unsigned half load
    put(32'h100, enc_u(32'hA1B2C, 2, OpLui));     // lui x2,0xA1B2C
    put(32'h104, enc_i(32'h3D4, 2, 0, 2, OpImm)); // addi x2,x2,0x3D4
    put(32'h108, enc_i(32'h200, 0, 0, 1, OpImm)); // addi x1,x0,0x200
    put(32'h10C, enc_s(3, 2, 1, 0));              // sb x2,3(x1)
    put(32'h110, enc_i(3, 1, 0, 3, OpLoad));      // lb x3,3(x1)
    put(32'h114, enc_i(2, 1, 5, 4, OpLoad));      // lhu x4,2(x1)
    put(32'h118, enc_s(32'h304, 3, 0, 2));        // sw x3,0x304(x0)
    put(32'h11C, enc_s(32'h308, 4, 0, 2));        // sw x4,0x308(x0)
    put(32'h120, Ecall);
    put(32'h200, 32'hD400_0000);
    do_reset();
    wait_halt(1'b0, 60, "mem_halt");
    check("sb_count", st_n, 32'd3);
    check("sb_be", {28'd0, st_be[0]}, 32'h8);
    check("sb_data", st_data[0], 32'hD4D4_D4D4);
    check("sb_addr", st_addr[0], 32'h200);
    check("lb_x3", st_data[1], 32'hFFFF_FFD4);
    check("lhu_x4", st_data[2], 32'h0000_D400);
    check("mem_retired", retired_count, 32'd8);
    check("mem_reads", rd_n, 32'd11);
    check("mem_pc", program_counter, 32'h120);

    // Misaligned word load
    put(32'h100, enc_i(2, 0, 2, 5, OpLoad));      // lw x5,2(x0)
    do_reset();
    wait_halt(1'b0, 10, "lw_halt");
    check("lw_cause", {30'd0, halt_cause}, 32'd2);
    check("lw_reads", rd_n, 32'd1);
    check("lw_stores", st_n, 32'd0);
    check("lw_retired", retired_count, 32'd0);
    check("lw_pc", program_counter, 32'h100);

    // Misaligned jump target; x1 still holds 0x200 from the previous program
    put(32'h100, enc_j(6, 1));                    // jal x1,+6
    do_reset();
    wait_halt(1'b0, 10, "jal_halt");
    check("jal_cause", {30'd0, halt_cause}, 32'd3);
    check("jal_pc", program_counter, 32'h100);
    check("jal_retired", retired_count, 32'd0);
    check("jal_x1_kept", dut.regs[1], 32'h200);

    // Reset during a stalled load
    put(32'h100, enc_i(32'h200, 0, 2, 6, OpLoad)); // lw x6,0x200(x0)
    do_reset();
    tick(1);
    hold = 1'b1;
    tick(1);
    check("stall_req", {31'd0, bus_request}, 32'd1);
    check("stall_addr", bus_address, 32'h200);
    check("stall_write", {31'd0, bus_write}, 32'd0);
    tick(2);
    check("stall_req_held", {31'd0, bus_request}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_req_drop", {31'd0, bus_request}, 32'd0);
    check("async_pc", program_counter, 32'h100);
    hold = 1'b0;
    tick(1);
    reset = 1'b0;
    #1;
    check("post_rst_req", {31'd0, bus_request}, 32'd1);
    check("post_rst_addr", bus_address, 32'h100);
    check("post_rst_halted", {31'd0, halted}, 32'd0);
    tick(3);
    check("post_rst_retired", retired_count, 32'd1);

    // RV32E: legal low registers, then rd=x17 is illegal
    tick(1);
    reset_e = 1'b0;
    wait_halt(1'b1, 30, "rv32e_halt");
    check("rv32e_cause", {30'd0, halt_cause_e}, 32'd1);
    check("rv32e_pc", program_counter_e, 32'h8);
    check("rv32e_retired", retired_count_e, 32'd2);
    check("rv32e_store", st_e_data, 32'd7);
    check("rv32e_store_n", st_e_n, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_core.md
Name: multicycle_core

Overview:
Parametrised multi-cycle RV32I/RV32E core. It replaces the single-cycle core's combinational program/data ports with one shared request/ready memory bus, so memories with wait states are supported. It adds asynchronous reset, byte-lane stores, alignment checking, halt reporting and a retired-instruction counter. It reuses the existing registers, alu and comparator blocks.

Parameters:
RESET_VECTOR, 32'h0000_0000, program_counter value after reset.
REGISTER_COUNT, 32, 32 gives RV32I; 16 gives RV32E (any rs1/rs2/rd with bit 4 set is illegal).
COUNTER_WIDTH, 32, width of retired_count.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
bus_request  output  1  memory transaction pending.
bus_write  output  1  1 = store, 0 = read.
bus_address  output  32  word-aligned address (bits [1:0] always 0).
bus_byte_enable  output  4  lane strobes; bit n is byte n; 4'b1111 on all reads.
bus_write_data  output  32  store data, replicated across lanes.
bus_ready  input  1  transaction completes on any rising edge where bus_request && bus_ready.
bus_read_data  input  32  sampled on the completing edge.
program_counter  output  32  address of the current instruction.
halted  output  1  core stopped.
halt_cause  output  2  0 ECALL/EBREAK, 1 illegal instruction, 2 misaligned load/store, 3 misaligned jump/branch target.
retired_count  output  COUNTER_WIDTH  count of instructions retired.

Behaviour:
- Reset (asynchronous, takes effect immediately): state=FETCH, program_counter=RESET_VECTOR, halted=0, halt_cause=0, retired_count=0, bus_request=0 while reset is high. The register file is not reset; x0 always reads 0.
- Reset mid-transaction: request drops at once, and a bus_ready on the same edge is ignored.
- States: FETCH, EXECUTE, MEMORY, HALT.
- FETCH: bus_request=1, bus_write=0, bus_address=program_counter.
  - Hold all bus outputs stable until the bus_ready edge.
  - On that edge, latch bus_read_data into the instruction register and go to EXECUTE.
- EXECUTE (exactly one cycle):
  - Decode, ALU and comparator operate on the latched instruction.
  - LUI, AUIPC, OP, OP-IMM, JAL, JALR, BRANCH and FENCE (executed as no-op): write rd (if any), update program_counter, retired_count+1, go to FETCH.
  - LOAD/STORE: address = rs1 + sign-extended immediate, latched; go to MEMORY.
- MEMORY:
  - Byte enables: SB uses 1<<addr[1:0]; SH uses 4'b0011 or 4'b1100 per addr[1]; SW uses 4'b1111.
  - Store data: byte replicated ×4, half-word replicated ×2.
  - Loads select lane by addr[1:0] and sign- or zero-extend per funct3.
  - On the bus_ready edge: write rd for loads, program_counter+=4, retired_count+1, go to FETCH.
- Control flow: JALR clears target bit 0. A taken branch, JAL or JALR whose target has bit 1 set → HALT with cause 3; rd is not written and PC is unchanged.
- Misaligned access (LW with addr[1:0]≠0, LH/LHU with addr[0]=1) → HALT with cause 2, detected in EXECUTE, no bus transaction issued.
- Illegal instruction → HALT with cause 1. This covers unknown opcode, undefined funct3/funct7, low bits ≠ 2'b11, and RV32E register ≥16.
- ECALL/EBREAK → HALT with cause 0.
- Halting instructions do not retire.
- HALT: bus_request=0, halted=1, program_counter frozen at the faulting instruction. Only reset leaves HALT.
- Latency with a zero-wait bus: 2 cycles per non-memory instruction, 3 per load/store. Each bus wait cycle adds 1.
- retired_count wraps modulo 2^COUNTER_WIDTH.
- rd = x0 writes are discarded.

Test Plan:
- Reset with RESET_VECTOR=32'h100, zero-wait bus → first request has address 32'h100; program_counter=32'h100; retired_count=0.
- Program `addi x1,x0,5; addi x2,x1,-7` → x2=32'hFFFF_FFFE; retired_count=2 after 4 cycles. With bus_ready low 3 cycles per fetch, completion takes 10 cycles.
- x1=32'h200, x2=32'hA1B2C3D4; `sb x2,3(x1)`; `lb x3,3(x1)`; `lhu x4,2(x1)` → store byte_enable 4'b1000 with data 32'hD4D4D4D4. With memory word 32'hD4000000: x3=32'hFFFF_FFD4, x4=32'h0000_D400.
- `lw x5,2(x0)` → halted=1, halt_cause=2, no MEMORY request, retired_count unchanged. `jal x1,+6` from a fresh reset → halt_cause=3, x1 unchanged.
- REGISTER_COUNT=16 with `add x17,x1,x2` → halt_cause 1. `ecall` → halt_cause 0 with program_counter at the ecall.
- Assert reset during a stalled load → bus_request falls the same cycle. After release, the first fetch is from RESET_VECTOR and halted=0.
